// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the execute stage and the mult/div unit
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, sign, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, sign, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t             state;
  logic               busy_q;
  logic               done_q;
  logic               div0_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Operation context captured when a start is accepted.
  logic               op_r;
  logic               neg_res;   // product / quotient must be negated in FIX
  logic               neg_rem;   // remainder must be negated in FIX (dividend was negative)
  logic               zero_div;  // divide with a zero divisor
  logic [WIDTH-1:0]   a_raw;     // unmodified dividend, returned in HI on divide-by-zero
  logic [WIDTH-1:0]   opnd;      // |a| for multiply, |b| for divide
  logic [CW-1:0]      cnt;

  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half holds dividend bits being shifted out and quotient bits shifted in.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Operand magnitudes, one datapath step for each algorithm, and sign fix-up of the final result.
  always_comb begin
    a_neg     = bus.sign & bus.a[WIDTH-1];
    b_neg     = bus.sign & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;

    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};

    // The remainder is always below the divisor, so the low WIDTH bits of the
    // difference are exact whenever the trial subtraction succeeds.
    div_shift = {rem, acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;

    prod_fix  = neg_res ? -acc : acc;
    quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? -rem : rem;

    res_hi    = '0;
    res_lo    = '0;
    if (!op_r) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (zero_div) begin
      res_hi = a_raw;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  // Control FSM, iteration datapath, HI/LO registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_r     <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      zero_div <= 1'b0;
      a_raw    <= '0;
      opnd     <= '0;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;

      // MTHI/MTLO only land while the unit is not busy; a result written later wins.
      if (!busy_q && bus.hi_we) hi_q <= bus.wdata;
      if (!busy_q && bus.lo_we) lo_q <= bus.wdata;

      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (bus.start && !bus.flush) begin
            busy_q   <= 1'b1;
            op_r     <= bus.op;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            zero_div <= bus.op && (bus.b == '0);
            a_raw    <= bus.a;
            cnt      <= '0;
            rem      <= '0;
            if (bus.op) begin
              state <= DIV;
              opnd  <= b_mag;
              acc   <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              state <= MUL;
              opnd  <= a_mag;
              acc   <= {{WIDTH{1'b0}}, b_mag};
            end
          end
        end

        MUL: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= FIX;
          end
        end

        DIV: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            rem <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            acc <= {{WIDTH{1'b0}}, acc[WIDTH-2:0], div_ge};
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= FIX;
          end
        end

        FIX: begin
          busy_q <= 1'b0;
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            state  <= DONE;
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
            div0_q <= zero_div;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed bench with cycle-level reference model for mult_div_unit
module tb_mult_div_unit;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic rst;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  // Reference state: what the architectural outputs must be, cycle by cycle.
  logic         m_busy;
  logic         m_done;
  logic         m_div0;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;
  int           m_left;
  logic [2*W:0] m_pend;

  // Result of one operation from plain arithmetic: {div0, hi, lo}.
  function automatic logic [2*W:0] ref_result(input logic op, input logic sg,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    if (!op) begin
      if (sg) p = longint'($signed(a)) * longint'($signed(b));
      else    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return {1'b0, p};
    end
    if (b == '0) return {1'b1, a, {W{1'b1}}};
    if (sg) begin
      if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) return {1'b0, {W{1'b0}}, a};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, r, q};
  endfunction

  // Reference model: latency counter from acceptance, flush/reset cancel, MT writes when idle.
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_div0 = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      m_div0 = 1'b0;
      if (!m_busy && bus.hi_we) m_hi = bus.wdata;
      if (!m_busy && bus.lo_we) m_lo = bus.wdata;
      if (m_busy) begin
        if (bus.flush) begin
          m_busy = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_div0 = m_pend[2*W];
            m_hi   = m_pend[2*W-1:W];
            m_lo   = m_pend[W-1:0];
          end
        end
      end else if (bus.start && !bus.flush) begin
        m_pend = ref_result(bus.op, bus.sign, bus.a, bus.b);
        m_busy = 1'b1;
        m_left = LAT - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the reference model.
  always @(negedge clk) begin
    if (checking) begin
      chk("model busy", 64'(bus.busy), 64'(m_busy));
      chk("model done", 64'(bus.done), 64'(m_done));
      chk("model div0", 64'(bus.div0), 64'(m_div0));
      chk("model hi",   64'(bus.hi),   64'(m_hi));
      chk("model lo",   64'(bus.lo),   64'(m_lo));
    end
  end

  // Issue one operation at the current negedge and wait for its done pulse.
  task automatic run_op(input string name, input logic op, input logic sg,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic ediv0);
    int lat = 0;
    bus.start = 1'b1;
    bus.op    = op;
    bus.sign  = sg;
    bus.a     = a;
    bus.b     = b;
    for (int i = 1; i <= LAT + 6; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    chk({name, " latency"}, 64'(lat), 64'(LAT));
    chk({name, " hi"}, 64'(bus.hi), 64'(ehi));
    chk({name, " lo"}, 64'(bus.lo), 64'(elo));
    chk({name, " div0"}, 64'(bus.div0), 64'(ediv0));
  endtask

  task automatic expect_no_done(input string name, input int cycles);
    int dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk({name, " spurious done"}, 64'(dones), 64'(0));
  endtask

  initial begin
    int dones;
    int lat;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    rst      = 1'b0;
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset done", 64'(bus.done), 64'(0));
    chk("reset div0", 64'(bus.div0), 64'(0));
    chk("reset hi",   64'(bus.hi),   64'(0));
    chk("reset lo",   64'(bus.lo),   64'(0));
    @(negedge clk);

    // Back-to-back chain: each op starts in the previous op's done cycle.
    run_op("multu max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult neg",  1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("mult min",  1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    repeat (2) @(negedge clk);
    run_op("div neg",   1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div ovf",   1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu",      1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0);
    run_op("divu zero", 1'b1, 1'b0, 32'd100,      32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    chk("div0 after done", 64'(bus.div0), 64'(0));

    // MTHI in idle, then an operation cancelled by flush in cycle 10.
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    dones     = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) dones++;
      if (i == 10) bus.flush = 1'b1;
    end
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy", 64'(bus.busy), 64'(0));
    chk("flush hi",   64'(bus.hi),   64'(32'h1234));
    chk("flush lo",   64'(bus.lo),   64'(0));
    chk("flush early done", 64'(dones), 64'(0));
    expect_no_done("flush", 40);

    // MT writes and a second start while busy are both ignored.
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    lat       = 0;
    for (int i = 1; i <= LAT + 6; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.hi_we = (i == 5);
      bus.lo_we = (i == 5);
      bus.wdata = 32'hDEAD;
      if (i == 6) chk("busy write hi", 64'(bus.hi), 64'(32'h1234));
      if (i == 8) begin
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("busy ops latency", 64'(lat), 64'(LAT));
    chk("busy ops hi", 64'(bus.hi), 64'(0));
    chk("busy ops lo", 64'(bus.lo), 64'(6));
    expect_no_done("ignored start", 40);

    // Reset in cycle 20 of a divide aborts it.
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.sign  = 1'b0;
    bus.a     = 32'd1000;
    bus.b     = 32'd7;
    dones     = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) dones++;
      if (i == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", 64'(bus.busy), 64'(0));
    chk("rst done", 64'(bus.done), 64'(0));
    chk("rst hi",   64'(bus.hi),   64'(0));
    chk("rst lo",   64'(bus.lo),   64'(0));
    chk("rst early done", 64'(dones), 64'(0));
    expect_no_done("rst", 40);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS core's execute stage. It executes MULT/MULTU/DIV/DIVU iteratively over WIDTH cycles and holds results in HI/LO for MFHI/MFLO. MTHI/MTLO use direct write ports. The pipeline stalls on `busy`, and a `flush` input cancels an in-flight operation on an exception.

## Interface
- WIDTH, 32, operand/HI/LO width; legal for any WIDTH ≥ 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request an operation; accepted only when busy=0.
- op  in  1  mult_op_enum value: 0 = ALU_MULT, 1 = ALU_DIV.
- sign  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  cancel the in-flight operation.
- hi_we, lo_we  in  1  MTHI/MTLO write enables.
- wdata  in  WIDTH  MTHI/MTLO write data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- div0  out  1  valid with done: the division had a zero divisor.
- hi, lo  out  WIDTH  architectural HI/LO registers.

## Operation
- States:
  - IDLE: on start, go to MUL or DIV according to op.
  - MUL and DIV: run for WIDTH iterations, then go to FIX.
  - FIX: go to DONE.
  - DONE: go to IDLE.
- Capture on accept: sign, op, |a| and |b| (magnitudes if sign=1, raw otherwise), result sign flags, and iteration counter = 0. The counter is $clog2(WIDTH)+1 bits wide.
- MUL: radix-2 shift-add on a 2·WIDTH-bit accumulator, one multiplier bit per cycle, LSB first.
- DIV: restoring division with one quotient bit per cycle, MSB first. The partial remainder is WIDTH+1 bits.
- FIX, signed multiply: negate the 2·WIDTH-bit product if sign(a)≠sign(b).
- FIX, signed divide:
  - Negate the quotient if sign(a)≠sign(b).
  - Negate the remainder if a<0.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
- Overflow case: signed −2^(WIDTH−1) / −1 gives lo = 0x80000000 and hi = 0 (WIDTH=32). No trap is raised.
- Zero divisor (b=0 on DIV/DIVU): lo = all ones, hi = a (raw), div0 = 1. The unit still runs the full WIDTH+2 cycle latency.
- Result write: at the FIX→DONE edge, hi ← product[2W−1:W] or remainder, and lo ← product[W−1:0] or quotient.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata at the next edge.
  - Writes while busy=1 are ignored; the pipeline must stall them.
  - If start and hi_we/lo_we arrive together in IDLE, the write takes effect and the later result overwrites it.
- start while busy=1 is ignored.
- flush:
  - In MUL, DIV or FIX, return to IDLE at the next edge with hi/lo unchanged and no done.
  - flush in IDLE or DONE has no effect. The DONE write has already happened.
  - flush together with start in IDLE: start is ignored.

## Timing
- Reset values: state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0. Reset mid-operation aborts it with no done.
- Start accepted at edge E0. busy=1 from E0 through the cycle before DONE. That covers WIDTH iteration cycles plus the FIX cycle.
- done=1 for exactly one cycle, WIDTH+2 cycles after E0 (cycle 34 for WIDTH=32). busy=0 in that cycle.
- A new start may be accepted in the done cycle, so back-to-back operations take WIDTH+2 cycles each.
- div0 is valid only while done=1 and is 0 otherwise.
- hi/lo are registered outputs. They are stable except at the result-write and MT-write edges.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done at cycle 34, hi=0xFFFFFFFE, lo=0x00000001, div0=0.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. Also DIVU 0xFFFFFFF9/2 → lo=0x7FFFFFFC, hi=1.
- DIVU a=100, b=0 → done=1, div0=1, lo=0xFFFFFFFF, hi=0x64.
- flush and writes:
  - hi_we with wdata=0x1234 in IDLE, then MULTU 5×6, then flush at cycle 10 → busy=0 next cycle, no done, hi=0x1234, lo=0.
  - hi_we while busy → hi unchanged.
- Control corner cases:
  - start pulsed while busy → ignored; only the first result appears.
  - rst asserted at cycle 20 → busy=0, hi=lo=0, no done.
  - Back-to-back start in the done cycle → second done exactly 34 cycles later.
